// File: rtl/fetch_unit.sv
// Instruction fetch front end: issues one icache request at a time and buffers
// returned words in a DEPTH-entry queue for decode. A redirect flushes everything.
`ifndef PC_RESET
`define PC_RESET 32'h0000_0000
`endif

module fetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = `PC_RESET
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     redirect_valid,
  input  logic [31:0]              redirect_pc,
  output logic                     icache_req_valid,
  input  logic                     icache_req_ready,
  output logic [31:0]              icache_addr,
  input  logic                     icache_resp_valid,
  input  logic [31:0]              icache_resp_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_pc_4,
  output logic [31:0]              out_inst,
  output logic [$clog2(DEPTH):0]   count
);

  // state | meaning
  // IDLE  | nothing outstanding; a request may issue
  // WAIT  | live request outstanding; its response is pushed
  // DROP  | stale request outstanding; its response is discarded

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   fpc_q, fpc_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_inst_q [DEPTH];

  logic not_full;
  logic req_fire;
  logic push;
  logic pop;

  assign not_full = (count_q < CW'(DEPTH));
  assign req_fire = icache_req_valid & icache_req_ready;
  assign pop      = out_valid & out_ready & ~redirect_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A response always returns the FSM to IDLE, whether it is kept or dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_fire) state_d = WAIT;
      end
      WAIT: begin
        if (icache_resp_valid)   state_d = IDLE;
        else if (redirect_valid) state_d = DROP;
      end
      DROP: begin
        if (icache_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issuing only when not full with a single outstanding request means a push
  // can never land on a full queue.
  always_comb begin
    icache_req_valid = 1'b0;
    push             = 1'b0;
    if (!reset && !redirect_valid) begin
      icache_req_valid = (state_q == IDLE) && not_full;
      push             = (state_q == WAIT) && icache_resp_valid;
    end
  end

  always_comb begin
    fpc_d    = fpc_q;
    req_pc_d = req_pc_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      fpc_d    = redirect_pc;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (req_fire) begin
        req_pc_d = fpc_q;
        fpc_d    = fpc_q + 32'd4;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q    <= RESET_PC;
      req_pc_q <= RESET_PC;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      req_pc_q <= req_pc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc_q[wr_ptr_q]   <= req_pc_q;
      mem_inst_q[wr_ptr_q] <= icache_resp_data;
    end
  end

  assign icache_addr = fpc_q;
  assign count       = count_q;
  assign out_valid   = (count_q != '0);
  assign out_pc      = mem_pc_q[rd_ptr_q];
  assign out_pc_4    = mem_pc_q[rd_ptr_q] + 32'd4;
  assign out_inst    = mem_inst_q[rd_ptr_q];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: stimulus queues expected request addresses and
// decode entries; a negedge monitor pops and compares them as the DUT presents them.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;

  logic        clk;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        icache_req_valid;
  logic        icache_req_ready;
  logic [31:0] icache_addr;
  logic        icache_resp_valid;
  logic [31:0] icache_resp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_pc_4;
  logic [31:0] out_inst;
  logic [2:0]  count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] addr_q [$];
  logic [63:0] out_q  [$];

  fetch_unit #(.DEPTH(4), .RESET_PC(RPC)) dut (
    .clk               (clk),
    .reset             (reset),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .icache_req_valid  (icache_req_valid),
    .icache_req_ready  (icache_req_ready),
    .icache_addr       (icache_addr),
    .icache_resp_valid (icache_resp_valid),
    .icache_resp_data  (icache_resp_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_pc            (out_pc),
    .out_pc_4          (out_pc_4),
    .out_inst          (out_inst),
    .count             (count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // issue one request at addr, answer it the next cycle, then return to idle
  task automatic fetch_one(input logic [31:0] a, input bit keep);
    tick();
    icache_req_ready = 1'b1;
    addr_q.push_back(a);
    tick();
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = inst_of(a);
    if (keep) out_q.push_back({a, inst_of(a)});
    tick();
    icache_resp_valid = 1'b0;
  endtask

  // monitor: scoreboard for issued addresses and dequeued entries
  always @(negedge clk) begin
    logic [31:0] ea;
    logic [63:0] eo;
    if (!reset) begin
      if (icache_req_valid && icache_req_ready) begin
        if (addr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL req_addr: unexpected request to %h, none expected", icache_addr);
        end else begin
          ea = addr_q.pop_front();
          chk("req_addr", icache_addr, ea);
        end
      end
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL out_entry: unexpected entry pc %h, none expected", out_pc);
        end else begin
          eo = out_q.pop_front();
          chk("out_pc",   out_pc,   eo[63:32]);
          chk("out_inst", out_inst, eo[31:0]);
          chk("out_pc_4", out_pc_4, eo[63:32] + 32'd4);
        end
      end
    end
  end

  initial begin
    logic [31:0] nxt;
    reset             = 1'b1;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    icache_req_ready  = 1'b1;
    icache_resp_valid = 1'b0;
    icache_resp_data  = '0;
    out_ready         = 1'b0;

    // reset
    tick();
    @(negedge clk);
    chk("rst_req_valid", 32'(icache_req_valid), 32'd0);
    tick();
    reset            = 1'b0;
    icache_req_ready = 1'b0;
    @(negedge clk);
    chk("rst_count",     32'(count),            32'd0);
    chk("rst_out_valid", 32'(out_valid),        32'd0);
    chk("rst_req_valid", 32'(icache_req_valid), 32'd1);
    chk("rst_addr",      icache_addr,           RPC);

    // streaming, decode always ready, 1-cycle responses
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      nxt = RPC + 32'(4 * i);
      tick();
      icache_req_ready  = 1'b1;
      icache_resp_valid = 1'b0;
      addr_q.push_back(nxt);
      @(negedge clk);
      chk("s1_count_issue", 32'(count), (i > 0) ? 32'd1 : 32'd0);
      tick();
      icache_resp_valid = 1'b1;
      icache_resp_data  = inst_of(nxt);
      out_q.push_back({nxt, inst_of(nxt)});
      @(negedge clk);
      chk("s1_count_resp", 32'(count), 32'd0);
    end
    tick();
    icache_resp_valid = 1'b0;
    icache_req_ready  = 1'b0;
    @(negedge clk);
    chk("s1_count_last", 32'(count), 32'd1);
    tick();
    @(negedge clk);
    chk("s1_count_empty", 32'(count), 32'd0);

    // decode stalled: queue fills to DEPTH and issue stops
    out_ready = 1'b0;
    nxt = RPC + 32'd12;
    for (int i = 0; i < 4; i++) begin
      tick();
      icache_req_ready  = 1'b1;
      icache_resp_valid = 1'b0;
      addr_q.push_back(nxt + 32'(4 * i));
      @(negedge clk);
      chk("s2_count_issue", 32'(count), 32'(i));
      chk("s2_req_valid", 32'(icache_req_valid), 32'd1);
      tick();
      icache_resp_valid = 1'b1;
      icache_resp_data  = inst_of(nxt + 32'(4 * i));
      out_q.push_back({nxt + 32'(4 * i), inst_of(nxt + 32'(4 * i))});
    end
    tick();
    icache_resp_valid = 1'b0;
    @(negedge clk);
    chk("s2_count_full", 32'(count), 32'd4);
    chk("s2_req_valid_full", 32'(icache_req_valid), 32'd0);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("s2_count_pop", 32'(count), 32'd4);
    tick();
    out_ready = 1'b0;
    addr_q.push_back(nxt + 32'd16);
    @(negedge clk);
    chk("s2_count_after_pop", 32'(count), 32'd3);
    chk("s2_req_valid_after_pop", 32'(icache_req_valid), 32'd1);
    tick();
    icache_req_ready  = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = inst_of(nxt + 32'd16);
    out_q.push_back({nxt + 32'd16, inst_of(nxt + 32'd16)});
    tick();
    icache_resp_valid = 1'b0;
    @(negedge clk);
    chk("s2_count_refull", 32'(count), 32'd4);
    chk("s2_req_valid_refull", 32'(icache_req_valid), 32'd0);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("s2_count_drained", 32'(count), 32'd0);

    // redirect while waiting, response arrives two cycles later and is dropped
    nxt = RPC + 32'd32;
    tick();
    icache_req_ready = 1'b1;
    addr_q.push_back(nxt);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3000;
    @(negedge clk);
    chk("s3_req_valid_redir", 32'(icache_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("s3_req_valid_drop", 32'(icache_req_valid), 32'd0);
    tick();
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hDEAD_BEEF;
    tick();
    icache_resp_valid = 1'b0;
    icache_req_ready  = 1'b0;
    @(negedge clk);
    chk("s3_count", 32'(count), 32'd0);
    chk("s3_out_valid", 32'(out_valid), 32'd0);
    chk("s3_req_valid", 32'(icache_req_valid), 32'd1);
    chk("s3_addr", icache_addr, 32'h0000_3000);
    fetch_one(32'h0000_3000, 1'b1);
    tick();
    @(negedge clk);
    chk("s3_count_end", 32'(count), 32'd0);

    // redirect in the same cycle as the response
    tick();
    icache_req_ready = 1'b1;
    addr_q.push_back(32'h0000_3004);
    tick();
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hBAD0_0001;
    redirect_valid    = 1'b1;
    redirect_pc       = 32'h0000_5000;
    @(negedge clk);
    chk("s4_req_valid_redir", 32'(icache_req_valid), 32'd0);
    tick();
    icache_resp_valid = 1'b0;
    redirect_valid    = 1'b0;
    icache_req_ready  = 1'b0;
    @(negedge clk);
    chk("s4_count", 32'(count), 32'd0);
    chk("s4_req_valid", 32'(icache_req_valid), 32'd1);
    chk("s4_addr", icache_addr, 32'h0000_5000);
    fetch_one(32'h0000_5000, 1'b1);
    tick();

    // redirect in IDLE flushes a non-empty queue; target near the top of memory
    out_ready = 1'b0;
    fetch_one(32'h0000_5004, 1'b0);
    fetch_one(32'h0000_5008, 1'b0);
    @(negedge clk);
    chk("s5_count_two", 32'(count), 32'd2);
    tick();
    redirect_valid   = 1'b1;
    redirect_pc      = 32'hFFFF_FFFC;
    icache_req_ready = 1'b1;
    @(negedge clk);
    chk("s5_req_valid_redir", 32'(icache_req_valid), 32'd0);
    tick();
    redirect_valid   = 1'b0;
    icache_req_ready = 1'b0;
    @(negedge clk);
    chk("s5_count_flushed", 32'(count), 32'd0);
    chk("s5_out_valid", 32'(out_valid), 32'd0);
    chk("s5_addr", icache_addr, 32'hFFFF_FFFC);

    // address wrap
    out_ready = 1'b1;
    fetch_one(32'hFFFF_FFFC, 1'b1);
    @(negedge clk);
    chk("s6_out_pc_4_wrap", out_pc_4, 32'h0000_0000);
    chk("s6_addr_wrap", icache_addr, 32'h0000_0000);
    fetch_one(32'h0000_0000, 1'b1);
    tick();

    // reset while waiting; late response after reset is ignored
    tick();
    icache_req_ready = 1'b1;
    addr_q.push_back(32'h0000_0004);
    tick();
    reset            = 1'b1;
    icache_req_ready = 1'b0;
    @(negedge clk);
    chk("s7_req_valid_rst", 32'(icache_req_valid), 32'd0);
    tick();
    reset             = 1'b0;
    icache_resp_valid = 1'b1;
    icache_resp_data  = 32'hBAD0_0002;
    tick();
    icache_resp_valid = 1'b0;
    @(negedge clk);
    chk("s7_count", 32'(count), 32'd0);
    chk("s7_out_valid", 32'(out_valid), 32'd0);
    chk("s7_addr", icache_addr, RPC);
    fetch_one(RPC, 1'b1);
    tick();
    @(negedge clk);
    chk("s7_count_end", 32'(count), 32'd0);

    tick();
    chk("addr_q_left", 32'(addr_q.size()), 32'd0);
    chk("out_q_left",  32'(out_q.size()),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
